// File: rtl/seq_divider_pkg.sv
// Shared types for the iterative restoring divider.
package seq_divider_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

    localparam int unsigned DIV_DEF_WIDTH = 64;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface : seq_divider_if

// File: rtl/seq_divider_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module seq_divider_step #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH:0]   prem,
    input  logic             dbit,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   prem_next_c,
    output logic             qbit_c
);
    logic [WIDTH+1:0] shifted_c;
    logic [WIDTH+1:0] diff_c;

    // One extra guard bit so the borrow of the trial subtraction is always visible
    assign shifted_c   = {prem, dbit};
    assign diff_c      = shifted_c - {2'b00, dvs};
    assign qbit_c      = ~diff_c[WIDTH+1];
    assign prem_next_c = (WIDTH+1)'(qbit_c ? diff_c : shifted_c);
endmodule : seq_divider_step

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one division in flight, valid/ready on both sides.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH  = DIV_DEF_WIDTH,
    parameter bit          SIGNED = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);
    localparam int unsigned      CW      = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_raw, b_raw;
    logic [WIDTH-1:0] dvd_sh, dvs_mag, quo_acc;
    logic [WIDTH:0]   prem;
    logic             neg_q, neg_r;

    logic             a_neg_c, b_neg_c, ovf_c;
    logic [WIDTH-1:0] a_mag_c, b_mag_c, q_fix_c, r_fix_c;
    logic [WIDTH:0]   prem_next_c;
    logic             qbit_c;

    // Operand magnitudes and the MIN / -1 corner, evaluated from the captured operands
    assign a_neg_c = SIGNED && a_raw[WIDTH-1];
    assign b_neg_c = SIGNED && b_raw[WIDTH-1];
    assign a_mag_c = a_neg_c ? WIDTH'(-a_raw) : a_raw;
    assign b_mag_c = b_neg_c ? WIDTH'(-b_raw) : b_raw;
    assign ovf_c   = SIGNED && (a_raw == MIN_VAL) && (&b_raw);

    // Sign fix-up of the unsigned result
    assign q_fix_c = neg_q ? WIDTH'(-quo_acc) : quo_acc;
    assign r_fix_c = neg_r ? WIDTH'(-prem[WIDTH-1:0]) : prem[WIDTH-1:0];

    seq_divider_step #(.WIDTH(WIDTH)) u_step (
        .prem        (prem),
        .dbit        (dvd_sh[WIDTH-1]),
        .dvs         (dvs_mag),
        .prem_next_c (prem_next_c),
        .qbit_c      (qbit_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            count           <= '0;
            a_raw           <= '0;
            b_raw           <= '0;
            dvd_sh          <= '0;
            dvs_mag         <= '0;
            quo_acc         <= '0;
            prem            <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        a_raw        <= bus.dividend;
                        b_raw        <= bus.divisor;
                        bus.in_ready <= 1'b0;
                        state        <= PREP;
                    end
                end
                PREP: begin
                    neg_q   <= a_neg_c ^ b_neg_c;
                    neg_r   <= a_neg_c;
                    dvd_sh  <= a_mag_c;
                    dvs_mag <= b_mag_c;
                    quo_acc <= '0;
                    prem    <= '0;
                    count   <= CW'(WIDTH - 1);
                    if (b_raw == '0) begin
                        bus.quotient    <= '1;
                        bus.remainder   <= a_raw;
                        bus.div_by_zero <= 1'b1;
                        bus.overflow    <= 1'b0;
                        bus.out_valid   <= 1'b1;
                        state           <= DONE;
                    end else if (ovf_c) begin
                        bus.quotient    <= MIN_VAL;
                        bus.remainder   <= '0;
                        bus.div_by_zero <= 1'b0;
                        bus.overflow    <= 1'b1;
                        bus.out_valid   <= 1'b1;
                        state           <= DONE;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    prem    <= prem_next_c;
                    quo_acc <= {quo_acc[WIDTH-2:0], qbit_c};
                    dvd_sh  <= {dvd_sh[WIDTH-2:0], 1'b0};
                    count   <= count - CW'(1);
                    if (count == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    bus.quotient    <= q_fix_c;
                    bus.remainder   <= r_fix_c;
                    bus.div_by_zero <= 1'b0;
                    bus.overflow    <= 1'b0;
                    bus.out_valid   <= 1'b1;
                    state           <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Randomised self-checking bench: signed and unsigned dividers run the same stimulus against a plain-arithmetic model.
module tb_seq_divider;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] dividend;
    logic [63:0] divisor;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(64)) sif ();
    seq_divider_if #(.WIDTH(64)) uif ();

    assign sif.in_valid  = in_valid;
    assign sif.dividend  = dividend;
    assign sif.divisor   = divisor;
    assign sif.out_ready = out_ready;
    assign uif.in_valid  = in_valid;
    assign uif.dividend  = dividend;
    assign uif.divisor   = divisor;
    assign uif.out_ready = out_ready;

    seq_divider #(.WIDTH(64), .SIGNED(1'b1)) u_dut_s (.clk(clk), .reset(reset), .bus(sif));
    seq_divider #(.WIDTH(64), .SIGNED(1'b0)) u_dut_u (.clk(clk), .reset(reset), .bus(uif));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: language division semantics plus the two flagged corners
    task automatic ref_div(input bit sgn, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] q, output logic [63:0] r,
                           output logic dz, output logic ov, output int lat);
        dz  = 1'b0;
        ov  = 1'b0;
        lat = 66;
        if (b == 64'd0) begin
            q = '1; r = a; dz = 1'b1; lat = 1;
        end else if (sgn && a == MIN64 && b == '1) begin
            q = MIN64; r = 64'd0; ov = 1'b1; lat = 1;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic accept(input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        check("in_ready_s", 64'(sif.in_ready), 64'd1);
        check("in_ready_u", 64'(uif.in_ready), 64'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input int hold);
        logic [63:0] qs, rs, qu, ru;
        logic        dzs, ovs, dzu, ovu;
        int          ls, lu, gs, gu, cyc;
        ref_div(1'b1, a, b, qs, rs, dzs, ovs, ls);
        ref_div(1'b0, a, b, qu, ru, dzu, ovu, lu);
        accept(a, b);
        gs = 0; gu = 0; cyc = 0;
        while ((gs == 0 || gu == 0) && cyc < 150) begin
            @(posedge clk);
            #1;
            cyc++;
            if (sif.out_valid && gs == 0) gs = cyc;
            if (uif.out_valid && gu == 0) gu = cyc;
        end
        check("latency_s", 64'(gs), 64'(ls));
        check("latency_u", 64'(gu), 64'(lu));
        check("quot_s", sif.quotient, qs);
        check("rem_s", sif.remainder, rs);
        check("dbz_s", 64'(sif.div_by_zero), 64'(dzs));
        check("ovf_s", 64'(sif.overflow), 64'(ovs));
        check("quot_u", uif.quotient, qu);
        check("rem_u", uif.remainder, ru);
        check("dbz_u", 64'(uif.div_by_zero), 64'(dzu));
        check("ovf_u", 64'(uif.overflow), 64'(ovu));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = (i == 3);
            dividend = 64'd5;
            divisor  = 64'd1;
            @(posedge clk);
            #1;
            check("hold_quot_s", sif.quotient, qs);
            check("hold_rem_s", sif.remainder, rs);
            check("hold_quot_u", uif.quotient, qu);
            check("hold_valid_s", 64'(sif.out_valid), 64'd1);
            check("hold_ready_s", 64'(sif.in_ready), 64'd0);
            check("hold_ready_u", 64'(uif.in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_ready_s", 64'(sif.in_ready), 64'd1);
        check("post_ready_u", 64'(uif.in_ready), 64'd1);
        check("post_valid_s", 64'(sif.out_valid), 64'd0);
        check("post_valid_u", 64'(uif.out_valid), 64'd0);
        if (hold > 0) begin
            repeat (3) @(posedge clk);
            #1;
            check("ignored_valid_s", 64'(sif.out_valid), 64'd0);
            check("ignored_ready_s", 64'(sif.in_ready), 64'd1);
        end
    endtask

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: v = 64'd0;
            1: v = '1;
            2: v = MIN64;
            3: v = 64'($urandom_range(0, 20));
            4: v = v >> $urandom_range(0, 63);
            5: v = -(v >> $urandom_range(0, 63));
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        check("rst_ready_s", 64'(sif.in_ready), 64'd1);
        check("rst_valid_s", 64'(sif.out_valid), 64'd0);
        check("rst_quot_s", sif.quotient, 64'd0);
        check("rst_rem_s", sif.remainder, 64'd0);
        check("rst_flags_s", {62'd0, sif.div_by_zero, sif.overflow}, 64'd0);
        check("rst_valid_u", 64'(uif.out_valid), 64'd0);
        reset = 1'b1;

        run_op(64'd1000, 64'd7, 0);
        run_op(-64'd1000, 64'd7, 0);
        run_op(64'd1000, -64'd7, 0);
        run_op(-64'd1000, -64'd7, 0);
        run_op(64'd123, 64'd0, 0);
        run_op(MIN64, '1, 0);
        run_op(-64'd1000, 64'd7, 10);

        // Abort mid-iteration: count reaches 30 after the 34th edge following acceptance
        accept(64'd1000, 64'd7);
        repeat (34) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_valid_s", 64'(sif.out_valid), 64'd0);
        check("abort_ready_s", 64'(sif.in_ready), 64'd1);
        check("abort_valid_u", 64'(uif.out_valid), 64'd0);
        check("abort_ready_u", 64'(uif.in_ready), 64'd1);
        check("abort_quot_s", sif.quotient, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(64'd64, 64'd8, 0);

        for (int i = 0; i < 500; i++) begin
            run_op(rand_operand(), rand_operand(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_seq_divider
